// File: rtl/player_sprite_anim.sv
// Player sprite animation: status-driven frame sequencer, facing latch and
// combinational sprite-ROM addressing for the current pixel.
module player_sprite_anim #(
  parameter int SPR_W    = 28,
  parameter int SPR_H    = 62,
  parameter int ANIM_DIV = 8
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallSX,
  input  logic [9:0]  BallSY,
  input  logic [3:0]  BallStatus,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        facing_left,
  output logic [2:0]  anim_frame,
  output logic        in_sprite,
  output logic [13:0] sprite_addr
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {
    CLS_IDLE = 2'd0,
    CLS_WALK = 2'd1,
    CLS_JUMP = 2'd2,
    CLS_FALL = 2'd3
  } status_cls_e;

  status_cls_e      status_q, status_d, status_cls;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       frame_q, frame_d;
  logic             facing_q, facing_d;
  logic             tick;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      status_q <= CLS_IDLE;
      div_q    <= '0;
      frame_q  <= 3'd0;
      facing_q <= 1'b0;
    end else begin
      status_q <= status_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
      facing_q <= facing_d;
    end
  end

  // Out-of-range status codes fold into idle; a class change restarts the
  // animation and wins over a simultaneous step tick.
  always_comb begin
    status_cls = (BallStatus[3:2] == 2'b00) ? status_cls_e'(BallStatus[1:0]) : CLS_IDLE;
    tick       = (div_q == DIV_W'(ANIM_DIV - 1));
    status_d   = status_cls;
    div_d      = div_q;
    frame_d    = frame_q;
    facing_d   = facing_q;

    if (keycode == 8'h50) begin
      facing_d = 1'b1;
    end else if (keycode == 8'h4F) begin
      facing_d = 1'b0;
    end

    if (status_cls != status_q) begin
      div_d = '0;
      case (status_cls)
        CLS_IDLE: frame_d = 3'd0;
        CLS_WALK: frame_d = 3'd2;
        CLS_JUMP: frame_d = 3'd6;
        default:  frame_d = 3'd7;
      endcase
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        case (status_q)
          CLS_IDLE: frame_d = (frame_q == 3'd0) ? 3'd1 : 3'd0;
          CLS_WALK: frame_d = (frame_q >= 3'd5 || frame_q < 3'd2) ? 3'd2 : frame_q + 3'd1;
          CLS_JUMP: frame_d = 3'd6;
          default:  frame_d = 3'd7;
        endcase
      end
    end
  end

  logic signed [10:0] left_s, top_s, draw_x_s, draw_y_s, size_x_s, size_y_s;
  logic        [10:0] col, row, column;
  logic        [13:0] addr_full;

  // Box edges are 11-bit signed so a player partly off the left/top edge
  // still yields correct hit tests and offsets instead of wrapping.
  always_comb begin
    left_s   = $signed({1'b0, BallX}) - $signed({2'b00, BallSX[9:1]});
    top_s    = $signed({1'b0, BallY}) - $signed({2'b00, BallSY[9:1]});
    draw_x_s = $signed({1'b0, DrawX});
    draw_y_s = $signed({1'b0, DrawY});
    size_x_s = $signed({1'b0, BallSX});
    size_y_s = $signed({1'b0, BallSY});

    in_sprite = (draw_x_s >= left_s) && (draw_x_s < left_s + size_x_s) &&
                (draw_y_s >= top_s)  && (draw_y_s < top_s + size_y_s);

    col    = 11'(draw_x_s - left_s);
    row    = 11'(draw_y_s - top_s);
    column = facing_q ? 11'(SPR_W - 1) - col : col;

    addr_full   = 14'(frame_q) * 14'(SPR_W * SPR_H) + 14'(row) * 14'(SPR_W) + 14'(column);
    sprite_addr = in_sprite ? addr_full : 14'd0;
  end

  assign facing_left = facing_q;
  assign anim_frame  = frame_q;

endmodule

// File: tb/tb_player_sprite_anim.sv
// Directed self-checking bench for player_sprite_anim; every expected value
// below was worked out by hand from the frame map and box geometry.
module tb_player_sprite_anim;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic [9:0]  BallX, BallY, BallSX, BallSY;
  logic [3:0]  BallStatus;
  logic [9:0]  DrawX, DrawY;
  logic        facing_left;
  logic [2:0]  anim_frame;
  logic        in_sprite;
  logic [13:0] sprite_addr;

  int vectors     = 0;
  int miscompares = 0;

  player_sprite_anim dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .BallX       (BallX),
    .BallY       (BallY),
    .BallSX      (BallSX),
    .BallSY      (BallSY),
    .BallStatus  (BallStatus),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .facing_left (facing_left),
    .anim_frame  (anim_frame),
    .in_sprite   (in_sprite),
    .sprite_addr (sprite_addr)
  );

  always #5 frame_clk = ~frame_clk;

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) @(posedge frame_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Set draw coordinate, let combinational outputs settle, check both.
  task automatic checkPixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic exp_in, input logic [13:0] exp_addr);
    DrawX = x;
    DrawY = y;
    #1;
    checkOutput({tag, "_in"},   32'(in_sprite),   32'(exp_in));
    checkOutput({tag, "_addr"}, 32'(sprite_addr), 32'(exp_addr));
  endtask

  initial begin
    Reset      = 1'b1;
    keycode    = 8'h00;
    BallX      = 10'd320;
    BallY      = 10'd377;
    BallSX     = 10'd28;
    BallSY     = 10'd62;
    BallStatus = 4'd0;
    DrawX      = 10'd0;
    DrawY      = 10'd0;

    applyStimulus(2);
    checkOutput("rst_frame",  32'(anim_frame),  32'd0);
    checkOutput("rst_facing", 32'(facing_left), 32'd0);
    checkOutput("rst_div",    32'(dut.div_q),   32'd0);

    // Idle: toggles on edge 8 and back on edge 16.
    Reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("idle_e%0d", k), 32'(anim_frame),
                  (k >= 8 && k <= 15) ? 32'd1 : 32'd0);
    end

    // Walk: first edge loads 2, then steps every 8 edges.
    BallStatus = 4'd1;
    applyStimulus(1);
    checkOutput("walk_load",  32'(anim_frame), 32'd2);
    checkOutput("walk_div0",  32'(dut.div_q),  32'd0);
    applyStimulus(8);
    checkOutput("walk_3",     32'(anim_frame), 32'd3);
    applyStimulus(8);
    checkOutput("walk_4",     32'(anim_frame), 32'd4);
    applyStimulus(7);
    checkOutput("walk_4hold", 32'(anim_frame), 32'd4);
    checkOutput("walk_tickc", 32'(dut.div_q),  32'd7);

    // Change to jump on the tick cycle beats the walk step.
    BallStatus = 4'd2;
    applyStimulus(1);
    checkOutput("jump_load", 32'(anim_frame), 32'd6);
    checkOutput("jump_div0", 32'(dut.div_q),  32'd0);
    applyStimulus(8);
    checkOutput("jump_hold", 32'(anim_frame), 32'd6);

    BallStatus = 4'd3;
    applyStimulus(1);
    checkOutput("fall_load", 32'(anim_frame), 32'd7);
    BallStatus = 4'd9;
    applyStimulus(1);
    checkOutput("bad_status_idle", 32'(anim_frame), 32'd0);
    BallStatus = 4'd1;
    applyStimulus(1);
    checkOutput("walk_reload", 32'(anim_frame), 32'd2);
    applyStimulus(8);
    applyStimulus(8);
    applyStimulus(8);
    checkOutput("walk_5", 32'(anim_frame), 32'd5);
    applyStimulus(8);
    checkOutput("walk_wrap", 32'(anim_frame), 32'd2);

    // Facing latch.
    keycode = 8'h50;
    applyStimulus(1);
    checkOutput("face_left", 32'(facing_left), 32'd1);
    keycode = 8'h41;
    applyStimulus(1);
    checkOutput("face_hold", 32'(facing_left), 32'd1);
    keycode = 8'h4F;
    applyStimulus(1);
    checkOutput("face_right", 32'(facing_left), 32'd0);
    keycode = 8'h00;

    // Geometry at frame 0, facing right: box x 306..333, y 346..407.
    BallStatus = 4'd0;
    applyStimulus(1);
    checkOutput("geo_frame0", 32'(anim_frame), 32'd0);
    checkPixel("corner",   10'd306, 10'd346, 1'b1, 14'd0);
    checkPixel("right_ex", 10'd334, 10'd346, 1'b0, 14'd0);
    checkPixel("inner",    10'd310, 10'd350, 1'b1, 14'd116);
    checkPixel("below_ex", 10'd310, 10'd408, 1'b0, 14'd0);

    keycode = 8'h50;
    applyStimulus(1);
    keycode = 8'h00;
    checkOutput("mir_facing", 32'(facing_left), 32'd1);
    checkPixel("mir_corner", 10'd306, 10'd346, 1'b1, 14'd27);
    checkPixel("mir_left_ex", 10'd305, 10'd346, 1'b0, 14'd0);
    checkPixel("mir_far",    10'd333, 10'd346, 1'b1, 14'd0);

    // Left edge at -4, top edge at -21.
    keycode = 8'h4F;
    BallX   = 10'd10;
    applyStimulus(1);
    keycode = 8'h00;
    checkPixel("negx_0",    10'd0,    10'd346, 1'b1, 14'd4);
    checkPixel("negx_23",   10'd23,   10'd346, 1'b1, 14'd27);
    checkPixel("negx_24",   10'd24,   10'd346, 1'b0, 14'd0);
    checkPixel("negx_1020", 10'd1020, 10'd346, 1'b0, 14'd0);
    BallY = 10'd10;
    checkPixel("negy_0",    10'd0,    10'd0,   1'b1, 14'd592);
    checkPixel("negy_1023", 10'd0,    10'd1023, 1'b0, 14'd0);
    BallX = 10'd320;
    BallY = 10'd377;

    // Largest address: frame 7, bottom-right pixel.
    BallStatus = 4'd3;
    applyStimulus(1);
    checkPixel("max_addr", 10'd333, 10'd407, 1'b1, 14'd13887);
    BallStatus = 4'd1;
    applyStimulus(1);
    checkPixel("walk_addr", 10'd333, 10'd407, 1'b1, 14'd5207);

    // Reset mid-animation overrides the keycode and status updates.
    keycode = 8'h50;
    Reset   = 1'b1;
    applyStimulus(1);
    checkOutput("mid_rst_frame",  32'(anim_frame),  32'd0);
    checkOutput("mid_rst_facing", 32'(facing_left), 32'd0);
    checkOutput("mid_rst_div",    32'(dut.div_q),   32'd0);
    keycode = 8'h00;
    Reset   = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_frame", 32'(anim_frame), 32'd2);
    checkOutput("post_rst_div0",  32'(dut.div_q),  32'd0);
    applyStimulus(1);
    checkOutput("post_rst_div1",  32'(dut.div_q),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
